// File: rtl/ps2_sequence_arbiter.sv
// rtl/ps2_sequence_arbiter.sv - merges keyboard and mouse escape sequences into one byte stream
// Holds one pending sequence per source and sends each granted sequence whole over valid/ready.
module ps2_sequence_arbiter #(
  parameter bit ROUND_ROBIN    = 1'b1,
  parameter bit MOUSE_COALESCE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keyboard_sequence,
  input  logic [2:0]  keyboard_sequence_count,
  input  logic [31:0] mouse_sequence,
  input  logic [2:0]  mouse_sequence_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        keyboard_overflow,
  output logic        mouse_overflow
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state, state_next;
  logic        kbd_full, mouse_full;
  logic [31:0] kbd_seq, mouse_seq;
  logic [2:0]  kbd_cnt, mouse_cnt;
  logic [31:0] shift_reg;
  logic [2:0]  remaining;
  logic        last_grant_mouse;

  logic        grant_kbd, grant_mouse, handshake;
  logic        kbd_strobe, mouse_strobe;
  logic [2:0]  kbd_cnt_in, mouse_cnt_in;
  logic        kbd_full_next, mouse_full_next;
  logic        kbd_load, mouse_load;
  logic        kbd_ovf_next, mouse_ovf_next;
  logic [31:0] shift_next;
  logic [2:0]  remaining_next;
  logic        tx_valid_next;
  logic [7:0]  tx_data_next;

  assign kbd_strobe   = |keyboard_sequence_count;
  assign mouse_strobe = |mouse_sequence_count;
  assign kbd_cnt_in   = (keyboard_sequence_count > 3'd4) ? 3'd4 : keyboard_sequence_count;
  assign mouse_cnt_in = (mouse_sequence_count > 3'd4) ? 3'd4 : mouse_sequence_count;
  assign handshake    = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Keyboard wins a tie unless round-robin says the mouse is owed a turn.
  always_comb begin
    state_next  = state;
    grant_kbd   = 1'b0;
    grant_mouse = 1'b0;
    case (state)
      IDLE: begin
        if (kbd_full && (!mouse_full || !ROUND_ROBIN || last_grant_mouse)) begin
          grant_kbd  = 1'b1;
          state_next = SEND;
        end else if (mouse_full) begin
          grant_mouse = 1'b1;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (handshake && remaining == 3'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A strobe landing on the cycle its pending slot is granted refills the slot.
  always_comb begin
    kbd_full_next   = kbd_full & ~grant_kbd;
    mouse_full_next = mouse_full & ~grant_mouse;
    kbd_load        = 1'b0;
    mouse_load      = 1'b0;
    kbd_ovf_next    = 1'b0;
    mouse_ovf_next  = 1'b0;
    if (kbd_strobe) begin
      if (kbd_full_next) begin
        kbd_ovf_next = 1'b1;
      end else begin
        kbd_load      = 1'b1;
        kbd_full_next = 1'b1;
      end
    end
    if (mouse_strobe) begin
      if (mouse_full_next) begin
        mouse_ovf_next = 1'b1;
        mouse_load     = MOUSE_COALESCE;
      end else begin
        mouse_load      = 1'b1;
        mouse_full_next = 1'b1;
      end
    end
  end

  always_comb begin
    shift_next     = shift_reg;
    remaining_next = remaining;
    tx_valid_next  = tx_valid;
    tx_data_next   = tx_data;
    if (grant_kbd) begin
      shift_next     = kbd_seq;
      remaining_next = kbd_cnt;
      tx_valid_next  = 1'b1;
      tx_data_next   = kbd_seq[31:24];
    end else if (grant_mouse) begin
      shift_next     = mouse_seq;
      remaining_next = mouse_cnt;
      tx_valid_next  = 1'b1;
      tx_data_next   = mouse_seq[31:24];
    end else if (state == SEND && handshake) begin
      if (remaining > 3'd1) begin
        shift_next     = {shift_reg[23:0], 8'h00};
        remaining_next = remaining - 3'd1;
        tx_data_next   = shift_reg[23:16];
      end else begin
        tx_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_full          <= 1'b0;
      mouse_full        <= 1'b0;
      kbd_seq           <= 32'h0;
      mouse_seq         <= 32'h0;
      kbd_cnt           <= 3'd0;
      mouse_cnt         <= 3'd0;
      shift_reg         <= 32'h0;
      remaining         <= 3'd0;
      last_grant_mouse  <= 1'b1;
      tx_valid          <= 1'b0;
      tx_data           <= 8'h00;
      busy              <= 1'b0;
      keyboard_overflow <= 1'b0;
      mouse_overflow    <= 1'b0;
    end else begin
      kbd_full   <= kbd_full_next;
      mouse_full <= mouse_full_next;
      if (kbd_load) begin
        kbd_seq <= keyboard_sequence;
        kbd_cnt <= kbd_cnt_in;
      end
      if (mouse_load) begin
        mouse_seq <= mouse_sequence;
        mouse_cnt <= mouse_cnt_in;
      end
      if (grant_kbd)   last_grant_mouse <= 1'b0;
      if (grant_mouse) last_grant_mouse <= 1'b1;
      shift_reg         <= shift_next;
      remaining         <= remaining_next;
      tx_valid          <= tx_valid_next;
      tx_data           <= tx_data_next;
      busy              <= (state_next == SEND) | kbd_full_next | mouse_full_next;
      keyboard_overflow <= kbd_ovf_next;
      mouse_overflow    <= mouse_ovf_next;
    end
  end

endmodule
